// File: rtl/inv_diffusion_iter.sv
// Iterative inverse of the Ascon linear diffusion layer.
// Each row obeys L^64 = identity with L(x) = x ^ ror(x,a) ^ ror(x,b), so the
// inverse is obtained by applying the forward row diffusion 63 times,
// UNROLL applications per clock. Valid/ready handshake on input and output.

package ascon_pack;
  // Five 64-bit state rows; index 0 is row x0.
  typedef logic [4:0][63:0] type_state;
endpackage

module inv_diffusion_iter
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      valid_i,
  output logic      ready_o,
  input  type_state state_i,
  output logic      valid_o,
  input  logic      ready_i,
  output type_state state_o,
  output logic      busy_o
);

  localparam int ITER  = 63 / UNROLL;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  if (63 % UNROLL != 0) begin : g_bad_unroll
    $error("inv_diffusion_iter: UNROLL=%0d does not divide 63", UNROLL);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  type_state        state_q;
  type_state        state_nxt;
  logic             accept;

  // Rotate right of a 64-bit row by a constant amount in 1..63.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One forward application of the linear layer on every row.
  function automatic type_state diffuse(input type_state s);
    type_state r;
    r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
    r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
    r[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
    r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
    r[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
    return r;
  endfunction

  // UNROLL chained forward applications, the work done in one RUN cycle.
  function automatic type_state diffuse_n(input type_state s);
    type_state r;
    r = s;
    for (int k = 0; k < UNROLL; k++) begin
      r = diffuse(r);
    end
    return r;
  endfunction

  assign accept  = (fsm == IDLE) && valid_i && ready_o;
  assign state_o = state_q;

  // Combinational diffusion of the current state register.
  always_comb begin
    state_nxt = diffuse_n(state_q);
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm     <= IDLE;
      cnt     <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            fsm     <= RUN;
            cnt     <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          // This edge applies the final iteration.
          if (cnt == LAST) begin
            fsm     <= DONE;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
          end
        end
        DONE: begin
          // Ready stays low on the exit edge; the next accept happens from IDLE.
          if (ready_i) begin
            fsm     <= IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          fsm     <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // State register: loaded on accept, advanced every RUN cycle, held otherwise.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= '0;
    end else if (accept) begin
      state_q <= state_i;
    end else if (fsm == RUN) begin
      state_q <= state_nxt;
    end
  end

endmodule

// File: tb/tb_inv_diffusion_iter.sv
// Bench for inv_diffusion_iter: three instances (UNROLL 1, 7, 63) share the
// same inputs; directed and random vectors checked against a forward model.

module tb_inv_diffusion_iter;
  import ascon_pack::*;

  logic      clk;
  logic      reset_i;
  logic      valid_i;
  logic      ready_i;
  type_state state_i;

  logic      vo   [3];
  logic      rdy  [3];
  logic      busy [3];
  type_state so   [3];

  int iters [3] = '{63, 9, 1};
  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_diffusion_iter #(.UNROLL(1)) u_dut0 (
    .clock_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(rdy[0]),
    .state_i(state_i), .valid_o(vo[0]), .ready_i(ready_i), .state_o(so[0]),
    .busy_o(busy[0]));
  inv_diffusion_iter #(.UNROLL(7)) u_dut1 (
    .clock_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(rdy[1]),
    .state_i(state_i), .valid_o(vo[1]), .ready_i(ready_i), .state_o(so[1]),
    .busy_o(busy[1]));
  inv_diffusion_iter #(.UNROLL(63)) u_dut2 (
    .clock_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(rdy[2]),
    .state_i(state_i), .valid_o(vo[2]), .ready_i(ready_i), .state_o(so[2]),
    .busy_o(busy[2]));

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    logic [127:0] t;
    t = {x, x};
    return t[n +: 64];
  endfunction

  // Forward Ascon linear layer, used to build inputs from known results.
  function automatic type_state fwd(input type_state s);
    type_state r;
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) r[i] = s[i] ^ rot(s[i], ra[i]) ^ rot(s[i], rb[i]);
    return r;
  endfunction

  function automatic type_state rnd_state();
    type_state r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  // Push one state through all instances; optionally stall the DONE handshake.
  task automatic run_vec(input string nm, input type_state din, input type_state expv,
                         input bit hold);
    bit seen [3];
    int lat  [3];
    bit all;
    for (int d = 0; d < 3; d++) begin
      seen[d] = 1'b0;
      lat[d]  = 0;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("%s_rdy_pre%0d", nm, d), 320'(rdy[d]), 320'd1);
    valid_i = 1'b1;
    state_i = din;
    @(negedge clk);
    valid_i = 1'b0;
    chk($sformatf("%s_busy0", nm), 320'(busy[0]), 320'd1);
    chk($sformatf("%s_rdy_run0", nm), 320'(rdy[0]), 320'd0);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk);
      #1;
      all = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (vo[d] && !seen[d]) begin
          seen[d] = 1'b1;
          lat[d]  = cyc;
        end
        all = all & seen[d];
      end
      if (all) break;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_seen%0d", nm, d), 320'(seen[d]), 320'd1);
      chk($sformatf("%s_lat%0d", nm, d), 320'(lat[d]), 320'(iters[d]));
      chk($sformatf("%s_state%0d", nm, d), so[d], expv);
    end
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("%s_hold_v%0d", nm, d), 320'(vo[d]), 320'd1);
          chk($sformatf("%s_hold_s%0d", nm, d), so[d], expv);
          chk($sformatf("%s_hold_r%0d", nm, d), 320'(rdy[d]), 320'd0);
        end
        valid_i = i[0];
        state_i = rnd_state();
      end
      @(negedge clk);
      valid_i = 1'b0;
      for (int d = 0; d < 3; d++) chk($sformatf("%s_hold_end%0d", nm, d), so[d], expv);
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_vdrop%0d", nm, d), 320'(vo[d]), 320'd0);
      chk($sformatf("%s_rdy_post%0d", nm, d), 320'(rdy[d]), 320'd1);
    end
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  initial begin
    type_state s;
    type_state e;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    state_i = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_v%0d", d), 320'(vo[d]), 320'd0);
      chk($sformatf("rst_s%0d", d), so[d], 320'd0);
      chk($sformatf("rst_r%0d", d), 320'(rdy[d]), 320'd1);
      chk($sformatf("rst_b%0d", d), 320'(busy[d]), 320'd0);
    end
    reset_i = 1'b0;

    // All-zero and all-ones are fixed points of L.
    run_vec("zero", '0, '0, 1'b0);
    s = {5{64'hFFFF_FFFF_FFFF_FFFF}};
    run_vec("ones", s, s, 1'b0);

    // Hand-computed single-bit rows.
    s = '0;
    s[2] = 64'h8400_0000_0000_0001;
    s[0] = 64'h0000_2010_0000_0001;
    e = '0;
    e[2] = 64'h1;
    e[0] = 64'h1;
    run_vec("bits", s, e, 1'b0);

    // Random round trips through the forward model; one with a stalled handshake.
    for (int i = 0; i < 30; i++) begin
      e = rnd_state();
      run_vec($sformatf("rnd%0d", i), fwd(e), e, (i == 3));
    end

    // Reset in the middle of RUN (UNROLL=1) and while the faster ones sit in DONE.
    e = rnd_state();
    @(negedge clk);
    valid_i = 1'b1;
    state_i = fwd(e);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_busy0", 320'(busy[0]), 320'd1);
    reset_i = 1'b1;
    valid_i = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid_v%0d", d), 320'(vo[d]), 320'd0);
      chk($sformatf("mid_s%0d", d), so[d], 320'd0);
      chk($sformatf("mid_r%0d", d), 320'(rdy[d]), 320'd1);
    end
    @(negedge clk);
    chk("mid_ign_b0", 320'(busy[0]), 320'd0);
    chk("mid_ign_s0", so[0], 320'd0);
    valid_i = 1'b0;
    reset_i = 1'b0;
    e = rnd_state();
    run_vec("after_rst", fwd(e), e, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
